neopixel_multi_ctrl: RTL and testbench



---
 rtl/neopixel_pkg.sv | 41 ++++
 rtl/neopixel_multi_ctrl_serializer.sv | 116 +++++++++++
 rtl/neopixel_multi_ctrl.sv | 54 +++++
 tb/tb_neopixel_multi_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and helpers for the multi-channel NeoPixel serializer.
// Timing fields are cycle counts; helpers apply the minimum-of-one guards.
package neopixel_pkg;

  localparam int TimingW  = 16;
  localparam int RgbBits  = 24;
  localparam int RgbwBits = 32;

  typedef struct packed {
    logic [TimingW-1:0] t0h;
    logic [TimingW-1:0] t1h;
    logic [TimingW-1:0] period;
    logic [TimingW-1:0] latch;
  } neopixel_timing_t;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} nchan_state_e;

  // Optional G/R byte swap, then left-align so the first bit sits at [31].
  function automatic logic [31:0] load_sr(input logic [31:0] d, input logic rgbw,
                                          input logic swap);
    logic [31:0] w;
    w = swap ? {d[31:24], d[15:8], d[23:16], d[7:0]} : d;
    return rgbw ? w : {w[23:0], 8'h00};
  endfunction

  function automatic logic [TimingW-1:0] high_time(input logic b, input neopixel_timing_t t);
    logic [TimingW-1:0] th;
    th = b ? t.t1h : t.t0h;
    return (th == '0) ? TimingW'(1) : th;
  endfunction

  function automatic logic [TimingW-1:0] low_time(input neopixel_timing_t t,
                                                  input logic [TimingW-1:0] th);
    return (t.period > th) ? t.period - th : TimingW'(1);
  endfunction

  function automatic logic [TimingW-1:0] latch_time(input neopixel_timing_t t);
    return (t.latch == '0) ? TimingW'(1) : t.latch;
  endfunction

endpackage

// File: rtl/neopixel_multi_ctrl_serializer.sv
// One NeoPixel channel: pixel handshake, per-bit high/low timing, frame latch.
// Timing is captured at the first pixel of a frame and held until the latch ends.
module neopixel_chan_serializer
  import neopixel_pkg::*;
#(
  parameter int TimingWidth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  neopixel_timing_t timing_i,
  input  logic             rgbw_i,
  input  logic             grb_swap_i,
  input  logic             enable_i,
  input  logic             pixel_valid_i,
  input  logic [31:0]      pixel_data_i,
  output logic             pixel_ready_o,
  output logic             data_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  nchan_state_e           state_q, state_d;
  logic [TimingWidth-1:0] cnt_q, cnt_d;
  logic [31:0]            sr_q, sr_d;
  logic [5:0]             bitcnt_q, bitcnt_d;
  neopixel_timing_t       tim_q, tim_d;
  logic                   done_q, done_d;
  logic                   ready;
  logic [TimingW-1:0]     th;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    tim_d    = tim_q;
    done_d   = 1'b0;
    ready    = 1'b0;
    th       = high_time(sr_q[31], tim_q);
    case (state_q)
      IDLE: begin
        ready = enable_i;
        if (enable_i && pixel_valid_i) begin
          tim_d    = timing_i;
          sr_d     = load_sr(pixel_data_i, rgbw_i, grb_swap_i);
          bitcnt_d = rgbw_i ? 6'(RgbwBits) : 6'(RgbBits);
          cnt_d    = high_time(sr_d[31], timing_i) - 1'b1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          cnt_d   = low_time(tim_q, th) - 1'b1;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bitcnt_q > 6'd1) begin
          sr_d     = {sr_q[30:0], 1'b0};
          bitcnt_d = bitcnt_q - 1'b1;
          cnt_d    = high_time(sr_q[30], tim_q) - 1'b1;
          state_d  = HIGH;
        end else begin
          // Last LOW cycle of a pixel: a waiting pixel continues the frame gaplessly.
          ready = enable_i;
          if (enable_i && pixel_valid_i) begin
            sr_d     = load_sr(pixel_data_i, rgbw_i, grb_swap_i);
            bitcnt_d = rgbw_i ? 6'(RgbwBits) : 6'(RgbBits);
            cnt_d    = high_time(sr_d[31], tim_q) - 1'b1;
            state_d  = HIGH;
          end else begin
            cnt_d   = latch_time(tim_q) - 1'b1;
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    sr_q     <= sr_d;
    bitcnt_q <= bitcnt_d;
    tim_q    <= tim_d;
  end

  assign pixel_ready_o = ready & ~rst_i;
  assign data_o        = (state_q == HIGH);
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = done_q;

endmodule

// File: rtl/neopixel_multi_ctrl.sv
// Multi-channel NeoPixel controller: independent serializers per line plus
// a registered interrupt combining the enabled frame-done pulses.
module neopixel_multi_ctrl
  import neopixel_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int TimingWidth = 16,
  parameter int PixelWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  neopixel_timing_t                timing_i,
  input  logic                            rgbw_i,
  input  logic                            grb_swap_i,
  input  logic [NumChannels-1:0]          enable_i,
  input  logic [NumChannels-1:0]          irq_en_i,
  input  logic [NumChannels-1:0]          pixel_valid_i,
  input  logic [NumChannels*PixelWidth-1:0] pixel_data_i,
  output logic [NumChannels-1:0]          pixel_ready_o,
  output logic [NumChannels-1:0]          data_o,
  output logic [NumChannels-1:0]          busy_o,
  output logic [NumChannels-1:0]          frame_done_o,
  output logic                            irq_o
);

  logic irq_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    neopixel_chan_serializer #(
      .TimingWidth(TimingWidth)
    ) u_ser (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .timing_i     (timing_i),
      .rgbw_i       (rgbw_i),
      .grb_swap_i   (grb_swap_i),
      .enable_i     (enable_i[c]),
      .pixel_valid_i(pixel_valid_i[c]),
      .pixel_data_i (pixel_data_i[c*PixelWidth +: PixelWidth]),
      .pixel_ready_o(pixel_ready_o[c]),
      .data_o       (data_o[c]),
      .busy_o       (busy_o[c]),
      .frame_done_o (frame_done_o[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= |(frame_done_o & irq_en_i);
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_neopixel_multi_ctrl.sv
// Scoreboard bench: drivers push expected per-bit high/low durations derived
// from the pixel value and frame timing; a line monitor decodes data_o and compares.
module tb_neopixel_multi_ctrl;
  import neopixel_pkg::*;

  localparam int NCH = 4;

  typedef struct {
    int hi;
    int lo;
    bit fend;
  } exp_t;

  logic clk = 1'b0;
  logic rst_r = 1'b1;
  neopixel_timing_t timing_r;
  logic rgbw_r = 1'b0, swap_r = 1'b0;
  logic [NCH-1:0] enable_r = '1, irq_en_r = '1;
  logic vld_a [NCH];
  logic [31:0] pdata [NCH];
  logic [NCH-1:0] valid_bus;
  logic [NCH*32-1:0] pdata_bus;
  logic [NCH-1:0] pixel_ready_o, data_o, busy_o, frame_done_o;
  logic irq_o;

  exp_t exp_q [NCH][$];
  logic [31:0] frame_px [NCH][8];
  bit fm_rgbw [NCH][8];
  bit fm_swap [NCH][8];

  int total = 0, bad = 0;
  int hi_run [NCH];
  int lo_run [NCH];
  bit prev_irq_exp = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    valid_bus = '0;
    pdata_bus = '0;
    for (int c = 0; c < NCH; c++) begin
      valid_bus[c] = vld_a[c];
      pdata_bus[c*32 +: 32] = pdata[c];
    end
  end

  neopixel_multi_ctrl #(.NumChannels(NCH), .TimingWidth(16), .PixelWidth(32)) dut (
    .clk_i(clk), .rst_i(rst_r), .timing_i(timing_r), .rgbw_i(rgbw_r),
    .grb_swap_i(swap_r), .enable_i(enable_r), .irq_en_i(irq_en_r),
    .pixel_valid_i(valid_bus), .pixel_data_i(pdata_bus),
    .pixel_ready_o(pixel_ready_o), .data_o(data_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .irq_o(irq_o)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: every bit lasts exactly one period (guarded); the last bit
  // of a frame carries the latch time in its low phase.
  task automatic push_pixel(input int c, input logic [31:0] d, input bit rgbw,
                            input bit swap, input neopixel_timing_t t, input bit last);
    logic [31:0] w;
    logic b;
    int n, th, tl;
    exp_t e;
    w = swap ? {d[31:24], d[15:8], d[23:16], d[7:0]} : d;
    n = rgbw ? 32 : 24;
    for (int i = 0; i < n; i++) begin
      b  = rgbw ? w[31-i] : w[23-i];
      th = b ? int'(t.t1h) : int'(t.t0h);
      if (th == 0) th = 1;
      tl = (int'(t.period) > th) ? int'(t.period) - th : 1;
      e.hi = th;
      e.lo = tl;
      e.fend = 1'b0;
      if (last && i == n - 1) begin
        e.lo = tl + ((t.latch == 0) ? 1 : int'(t.latch));
        e.fend = 1'b1;
      end
      exp_q[c].push_back(e);
    end
  endtask

  task automatic pop_check(input int c, input bit fend);
    exp_t e;
    if (exp_q[c].size() == 0) begin
      chk($sformatf("ch%0d_unexpected_bit", c), exp_q[c].size(), 1);
    end else begin
      e = exp_q[c].pop_front();
      chk($sformatf("ch%0d_high_cycles", c), hi_run[c], e.hi);
      chk($sformatf("ch%0d_low_cycles", c), lo_run[c], e.lo);
      chk($sformatf("ch%0d_frame_end", c), fend, e.fend);
    end
  endtask

  always @(negedge clk) begin
    if (rst_r) begin
      for (int c = 0; c < NCH; c++) begin
        hi_run[c] = 0;
        lo_run[c] = 0;
      end
      prev_irq_exp = 1'b0;
    end else begin
      if (prev_irq_exp || irq_o) chk("irq", irq_o, prev_irq_exp);
      for (int c = 0; c < NCH; c++) begin
        if (frame_done_o[c]) begin
          pop_check(c, 1'b1);
          hi_run[c] = 0;
          lo_run[c] = 0;
        end else if (!busy_o[c]) begin
          hi_run[c] = 0;
          lo_run[c] = 0;
        end else if (data_o[c]) begin
          if (lo_run[c] > 0) begin
            pop_check(c, 1'b0);
            hi_run[c] = 0;
            lo_run[c] = 0;
          end
          hi_run[c]++;
        end else begin
          lo_run[c]++;
        end
      end
      prev_irq_exp = |(frame_done_o & irq_en_r);
    end
  end

  task automatic send_frame(input int c, input int n, input bit own_mode);
    neopixel_timing_t ft;
    bit ok;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      pdata[c] = frame_px[c][k];
      if (own_mode) begin
        rgbw_r = fm_rgbw[c][k];
        swap_r = fm_swap[c][k];
      end
      vld_a[c] = 1'b1;
      ok = 1'b0;
      for (int cy = 0; cy < 4000; cy++) begin
        @(negedge clk);
        if (pixel_ready_o[c]) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk($sformatf("ch%0d_handshake_timeout", c), pixel_ready_o[c], 1);
        vld_a[c] = 1'b0;
        return;
      end
      if (k == 0) ft = timing_r;
      push_pixel(c, frame_px[c][k], rgbw_r, swap_r, ft, k == n - 1);
      @(posedge clk); #1;
      if (k == 0) chk($sformatf("ch%0d_first_rise", c), data_o[c], 1);
      if (k == n - 1) vld_a[c] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int cy = 0; cy < 20000; cy++) begin
      @(negedge clk);
      if (busy_o == '0) break;
    end
    chk("idle_reached", busy_o, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic set_timing(input int t0, input int t1, input int per, input int lat);
    timing_r.t0h = 16'(t0);
    timing_r.t1h = 16'(t1);
    timing_r.period = 16'(per);
    timing_r.latch = 16'(lat);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      vld_a[c] = 1'b0;
      pdata[c] = '0;
    end
    set_timing(20, 40, 62, 100);
    repeat (3) @(negedge clk);
    chk("rst_ready", pixel_ready_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_irq", irq_o, 0);
    @(posedge clk); #1 rst_r = 1'b0;
    @(negedge clk);
    chk("idle_ready_all", pixel_ready_o, 4'hF);
    enable_r = 4'b0101;
    @(negedge clk);
    chk("idle_ready_masked", pixel_ready_o, 4'b0101);
    @(posedge clk); #1 enable_r = '1;

    // Single RGB pixel with MSB and LSB set
    frame_px[0][0] = 32'h0080_0001;
    send_frame(0, 1, 1'b0);
    wait_idle();

    // Back-to-back pixels, valid held
    frame_px[0][0] = 32'h00FF_FFFF;
    frame_px[0][1] = 32'h0000_0000;
    send_frame(0, 2, 1'b0);
    wait_idle();

    // RGBW plain, then RGBW with G/R swap
    frame_px[1][0] = 32'h0000_00FF; fm_rgbw[1][0] = 1; fm_swap[1][0] = 0;
    send_frame(1, 1, 1'b1);
    wait_idle();
    frame_px[1][0] = 32'h0011_2233; fm_rgbw[1][0] = 1; fm_swap[1][0] = 1;
    send_frame(1, 1, 1'b1);
    wait_idle();
    rgbw_r = 0; swap_r = 0;

    // Four channels started together
    frame_px[0][0] = 32'h00A5_5A01;
    frame_px[1][0] = 32'h0012_3456;
    frame_px[2][0] = 32'h00FF_0000;
    frame_px[3][0] = 32'h0000_00FF;
    fork
      send_frame(0, 1, 1'b0);
      send_frame(1, 1, 1'b0);
      send_frame(2, 1, 1'b0);
      send_frame(3, 1, 1'b0);
    join
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      if (frame_done_o != '0) break;
    end
    chk("simul_frame_done", frame_done_o, 4'hF);
    @(negedge clk);
    chk("simul_irq_pulse", irq_o, 1);
    @(negedge clk);
    chk("simul_irq_single", irq_o, 0);
    wait_idle();

    // Timing changed mid-frame only affects the next frame
    frame_px[2][0] = 32'h00C3_3C81;
    frame_px[2][1] = 32'h0055_AA0F;
    fork
      send_frame(2, 2, 1'b0);
      begin
        repeat (200) @(posedge clk);
        #1 set_timing(20, 40, 30, 100);
      end
    join
    wait_idle();
    frame_px[2][0] = 32'h0081_8181;
    send_frame(2, 1, 1'b0);
    wait_idle();
    set_timing(20, 40, 62, 100);

    // Reset in the middle of bit 5
    pdata[1] = 32'h00F0_F0F0;
    vld_a[1] = 1'b1;
    for (int cy = 0; cy < 100; cy++) begin
      @(negedge clk);
      if (pixel_ready_o[1]) break;
    end
    push_pixel(1, 32'h00F0_F0F0, 1'b0, 1'b0, timing_r, 1'b1);
    @(posedge clk); #1 vld_a[1] = 1'b0;
    repeat (5 * 62 + 10) @(posedge clk);
    #1 rst_r = 1'b1;
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    @(posedge clk); #1;
    chk("midrst_data", data_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", frame_done_o, 0);
    chk("midrst_ready", pixel_ready_o, 0);
    rst_r = 1'b0;
    @(negedge clk);
    chk("postrst_ready", pixel_ready_o, 4'hF);
    frame_px[1][0] = 32'h0000_0F0F;
    send_frame(1, 1, 1'b0);
    wait_idle();

    // Guards: high longer than period, zero latch
    set_timing(20, 70, 62, 0);
    frame_px[3][0] = 32'h00F0_0F81;
    frame_px[3][1] = 32'h0000_0001;
    send_frame(3, 2, 1'b0);
    wait_idle();

    // Randomized frames, single channel with per-pixel mode then all channels
    for (int it = 0; it < 6; it++) begin
      set_timing($urandom_range(0, 4), $urandom_range(0, 9), $urandom_range(1, 10),
                 $urandom_range(0, 6));
      irq_en_r = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < 8; k++) begin
          frame_px[c][k] = $urandom;
          fm_rgbw[c][k] = 1'($urandom_range(0, 1));
          fm_swap[c][k] = 1'($urandom_range(0, 1));
        end
      send_frame(it % NCH, $urandom_range(1, 4), 1'b1);
      wait_idle();
      rgbw_r = 1'($urandom_range(0, 1));
      swap_r = 1'($urandom_range(0, 1));
      fork
        send_frame(0, $urandom_range(1, 3), 1'b0);
        send_frame(1, $urandom_range(1, 3), 1'b0);
        send_frame(2, $urandom_range(1, 3), 1'b0);
        send_frame(3, $urandom_range(1, 3), 1'b0);
      join
      wait_idle();
    end

    for (int c = 0; c < NCH; c++) chk($sformatf("ch%0d_leftover", c), exp_q[c].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
